// File: rtl/simt_scheduler.sv
// rtl/simt_scheduler.sv - SIMT block scheduler: per-lane PCs, min-PC selection, divergence/reconvergence
module simt_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8,
  parameter int TC_BITS           = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [TC_BITS-1:0]                   thread_count,
  input  logic                                 decoded_mem_read_enable,
  input  logic                                 decoded_mem_write_enable,
  input  logic                                 decoded_ret,
  input  logic [2:0]                           fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]       lsu_state,
  input  logic [PC_BITS*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [PC_BITS-1:0]                   current_pc,
  output logic [THREADS_PER_BLOCK-1:0]         active_mask,
  output logic                                 diverged,
  output logic [2:0]                           core_state,
  output logic                                 done
);

  localparam int T = THREADS_PER_BLOCK;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  state_t state, state_next;

  logic [PC_BITS-1:0] thread_pc [T];
  logic [T-1:0]       thread_done;
  logic [T-1:0]       enabled;

  logic [T-1:0]       launch_enabled;
  logic               lsu_busy;
  logic [PC_BITS-1:0] upd_pc [T];
  logic [T-1:0]       upd_done;
  logic [T-1:0]       live_next;
  logic [PC_BITS-1:0] min_pc;
  logic [T-1:0]       min_mask;

  assign core_state = state;

  // Lane i is enabled when i < thread_count; the loop bound caps the count at T.
  always_comb begin
    launch_enabled = '0;
    for (int i = 0; i < T; i++) begin
      launch_enabled[i] = (thread_count > TC_BITS'(i));
    end
  end

  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (active_mask[i] &&
          (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10)) begin
        lsu_busy = 1'b1;
      end
    end
  end

  // Post-update lane values feed the min-PC search in the same cycle.
  always_comb begin
    upd_done = thread_done;
    for (int i = 0; i < T; i++) begin
      upd_pc[i] = thread_pc[i];
      if (active_mask[i]) begin
        if (decoded_ret) begin
          upd_done[i] = 1'b1;
        end else begin
          upd_pc[i] = next_pc[PC_BITS*i +: PC_BITS];
        end
      end
    end
    live_next = enabled & ~upd_done;
    min_pc = '1;
    for (int i = 0; i < T; i++) begin
      if (live_next[i] && upd_pc[i] < min_pc) begin
        min_pc = upd_pc[i];
      end
    end
    min_mask = '0;
    for (int i = 0; i < T; i++) begin
      min_mask[i] = live_next[i] && (upd_pc[i] == min_pc);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = (launch_enabled == '0) ? S_DONE : S_FETCH;
      S_FETCH:   if (fetcher_state == 3'b010) state_next = S_DECODE;
      S_DECODE:  state_next = S_REQUEST;
      S_REQUEST: state_next = S_WAIT;
      S_WAIT: begin
        if (!((decoded_mem_read_enable || decoded_mem_write_enable) && lsu_busy)) begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: state_next = S_UPDATE;
      S_UPDATE:  state_next = (live_next == '0) ? S_DONE : S_FETCH;
      S_DONE:    if (!start) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_pc  <= '0;
      active_mask <= '0;
      diverged    <= 1'b0;
      done        <= 1'b0;
      thread_done <= '0;
      enabled     <= '0;
      for (int i = 0; i < T; i++) thread_pc[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            enabled     <= launch_enabled;
            thread_done <= '0;
            current_pc  <= '0;
            active_mask <= launch_enabled;
            diverged    <= 1'b0;
            done        <= (launch_enabled == '0);
            for (int i = 0; i < T; i++) thread_pc[i] <= '0;
          end
        end
        S_UPDATE: begin
          thread_done <= upd_done;
          for (int i = 0; i < T; i++) thread_pc[i] <= upd_pc[i];
          if (live_next == '0) begin
            done        <= 1'b1;
            active_mask <= '0;
            diverged    <= 1'b0;
          end else begin
            current_pc  <= min_pc;
            active_mask <= min_mask;
            diverged    <= (min_mask != live_next);
          end
        end
        S_DONE: begin
          if (!start) done <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/simt_scheduler.md
SIMT_SCHEDULER -- requirements
Module: simt_scheduler

Interface
REQ-001 SHALL have parameter THREADS_PER_BLOCK, default 4, number of thread lanes per core.
REQ-002 SHALL have parameter PC_BITS, default 8, program counter width.
REQ-003 SHALL have parameter TC_BITS, default $clog2(THREADS_PER_BLOCK)+1, width of thread_count.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  launch block; level-sensitive.
REQ-007 SHALL have port thread_count  input  TC_BITS  threads enabled in this block; sampled on launch.
REQ-008 SHALL have port decoded_mem_read_enable  input  1  current instruction reads memory.
REQ-009 SHALL have port decoded_mem_write_enable  input  1  current instruction writes memory.
REQ-010 SHALL have port decoded_ret  input  1  current instruction is RET.
REQ-011 SHALL have port fetcher_state  input  3  fetcher FSM state; 3'b010 = FETCHED.
REQ-012 SHALL have port lsu_state  input  2*THREADS_PER_BLOCK  per-lane LSU state, lane i at [2i+1:2i]; 01 = REQUESTING, 10 = WAITING.
REQ-013 SHALL have port next_pc  input  PC_BITS*THREADS_PER_BLOCK  per-lane next PC from the lane's PC unit, lane i at [PC_BITS*i +: PC_BITS].
REQ-014 SHALL have port current_pc  output  PC_BITS  PC being fetched and executed.
REQ-015 SHALL have port active_mask  output  THREADS_PER_BLOCK  lanes executing the current instruction.
REQ-016 SHALL have port diverged  output  1  active_mask is a strict subset of live lanes.
REQ-017 SHALL have port core_state  output  3  IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
REQ-018 SHALL have port done  output  1  all enabled lanes have executed RET.

Function
REQ-019 SHALL hold per-lane registers thread_pc[i] (PC_BITS) and thread_done[i], plus enabled mask.
REQ-020 Live lane SHALL mean enabled[i] and !thread_done[i].
REQ-021 IDLE with start=1: enabled = lanes i < min(thread_count, THREADS_PER_BLOCK); all thread_pc, current_pc = 0; thread_done = 0.
REQ-022 Same IDLE launch with nonzero effective count: active_mask = enabled; next state FETCH.
REQ-023 IDLE launch with thread_count=0: done=1, active_mask=0, next state DONE.
REQ-024 FETCH SHALL advance to DECODE on the first edge where fetcher_state==3'b010; otherwise hold.
REQ-025 DECODE->REQUEST and REQUEST->WAIT SHALL each take exactly one cycle.
REQ-026 WAIT with neither decoded_mem_*_enable asserted SHALL go to EXECUTE after one cycle regardless of lsu_state.
REQ-027 Otherwise WAIT SHALL hold while any lane with active_mask[i]=1 has lsu_state 01 or 10; inactive lanes' lsu_state is ignored.
REQ-028 EXECUTE->UPDATE SHALL take exactly one cycle.
REQ-029 UPDATE, per active lane: decoded_ret=1 sets thread_done[i]; else thread_pc[i] <= next_pc lane i.
REQ-030 Inactive lanes SHALL keep thread_pc and thread_done unchanged in UPDATE.
REQ-031 UPDATE SHALL select, from post-update values in the same cycle, min_pc = minimum thread_pc over live lanes (unsigned compare).
REQ-032 If no lane is live after UPDATE: done=1, active_mask=0, diverged=0, next state DONE.
REQ-033 Else: current_pc = min_pc; active_mask = live lanes whose thread_pc equals min_pc; next state FETCH.
REQ-034 Lanes reaching equal PCs SHALL merge into one active_mask (reconvergence), with no extra cycle.
REQ-035 diverged SHALL be registered, updated with active_mask: 1 iff active_mask != live mask.
REQ-036 DONE SHALL hold done=1 while start=1; on start=0, clear done and go IDLE next edge (relaunch allowed).
REQ-037 start changes outside IDLE/DONE SHALL be ignored.

Reset
REQ-038 On reset assertion, without a clock edge: core_state=IDLE, current_pc=0, active_mask=0, diverged=0, done=0, all thread_pc=0, thread_done=0, enabled=0.
REQ-039 Reset mid-operation SHALL abandon the block; first edge after deassertion with start=1 relaunches from PC 0.

Verification
REQ-040 Uniform: T=4, thread_count=4, next_pc all = pc+1, RET at pc 3 -> pc 0,1,2,3, active_mask 1111, diverged 0, done=1 after 4th UPDATE.
REQ-041 Divergence: at pc 2, next_pc lanes0..3 = 3,5,3,5 -> current_pc=3, mask 0101, diverged=1; lanes 0,2 then go to 5 -> current_pc=5, mask 1111, diverged=0.
REQ-042 Partial block: thread_count=2, lanes 2,3 lsu_state held 01, read enable set, lanes 0,1 lsu 11 -> mask 0011, WAIT exits after one cycle.
REQ-043 Empty: thread_count=0, start=1 -> core_state DONE, done=1 next edge; start=0 -> IDLE, done=0.
REQ-044 Split RET: lanes 0,1 RET at pc 4 while lanes 2,3 at pc 6 -> next current_pc=6, mask 1100, done=0 until lanes 2,3 RET.
REQ-045 Reset in WAIT: assert reset between edges -> all outputs at reset values immediately.
